// File: rtl/debug_rom_fetch_pkg.sv
// Shared types and constants for the debug ROM fetch unit.
package debug_rom_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

   localparam int unsigned ROM_WORDS_DEFAULT = 19;
   localparam int unsigned ADDR_W_DEFAULT    = 64;
   localparam int unsigned WORD_W            = 64;
   localparam int unsigned INSTR_W           = 32;

endpackage

// File: rtl/debug_rom_fetch_if.sv
// ROM word port plus instruction stream of the debug ROM fetch unit.
interface debug_rom_fetch_if
   import debug_rom_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) ();

   logic                req;
   logic [ADDR_W-1:0]   addr;
   logic [WORD_W-1:0]   rdata;
   logic                instr_valid;
   logic                instr_ready;
   logic [INSTR_W-1:0]  instr;
   logic [ADDR_W-1:0]   instr_addr;

   modport master (
      output req, addr, instr_valid, instr, instr_addr,
      input  rdata, instr_ready
   );

   modport slave (
      input  req, addr, instr_valid, instr, instr_addr,
      output rdata, instr_ready
   );

endinterface

// File: rtl/debug_rom_fetch_wordbuf.sv
// 64-bit word register with per-half valid bits; presents the lowest valid half.
module dbg_fetch_wordbuf
   import debug_rom_fetch_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clr_i,
   input  logic               load_i,
   input  logic [WORD_W-1:0]  load_data_i,
   input  logic               load_lo_vld_i,
   input  logic               consume_i,
   output logic [WORD_W-1:0]  word_o,
   output logic               vld_o,
   output logic               sel_hi_o,
   output logic [INSTR_W-1:0] half_o
);

   logic [WORD_W-1:0] data_r;
   logic              lo_vld_r;
   logic              hi_vld_r;

   // Word storage: clear beats load, load beats consume.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_r   <= {WORD_W{1'b0}};
         lo_vld_r <= 1'b0;
         hi_vld_r <= 1'b0;
      end else if (clr_i) begin
         lo_vld_r <= 1'b0;
         hi_vld_r <= 1'b0;
      end else if (load_i) begin
         data_r   <= load_data_i;
         lo_vld_r <= load_lo_vld_i;
         hi_vld_r <= 1'b1;
      end else if (consume_i) begin
         if (lo_vld_r) begin
            lo_vld_r <= 1'b0;
         end else begin
            hi_vld_r <= 1'b0;
         end
      end
   end

   // The high half is always the last to go, so it doubles as "buffer non-empty".
   assign word_o   = data_r;
   assign vld_o    = hi_vld_r;
   assign sel_hi_o = !lo_vld_r;
   assign half_o   = lo_vld_r ? data_r[INSTR_W-1:0] : data_r[WORD_W-1:INSTR_W];

endmodule

// File: rtl/debug_rom_fetch.sv
// Debug ROM fetch: reads 64-bit words and streams 32-bit instructions, low half first.
// Optional prefetch buffer enabled by DEBUG_ROM_FETCH_PREFETCH_EN.
module debug_rom_fetch
   import debug_rom_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
   parameter int unsigned ROM_WORDS = ROM_WORDS_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_addr_i,
   debug_rom_fetch_if.master bus,
   output logic              busy_o
);

   localparam logic [ADDR_W-4:0] WORD_ONE = {{(ADDR_W-4){1'b0}}, 1'b1};

   if (ROM_WORDS < 1) begin : g_bad_rom_words
      $error("ROM_WORDS must be at least 1");
   end

   fetch_state_e        state_r;
   fetch_state_e        state_nx_s;
   logic [ADDR_W-1:2]   fa_r;
   logic [ADDR_W-1:2]   fa_nx_s;
   logic [ADDR_W-4:0]   word_s;
   logic [ADDR_W-4:0]   word_inc_s;
   logic                hs_s;
   logic                hi_done_s;
   logic                pf_req_s;
   logic [1:0]          redirect_lsb_unused_s;

   logic                b0_clr_s;
   logic                b0_load_s;
   logic [WORD_W-1:0]   b0_data_s;
   logic                b0_lo_vld_s;
   logic                b0_vld_s;
   logic                b0_sel_hi_s;
   logic [INSTR_W-1:0]  b0_half_s;
   logic [WORD_W-1:0]   b0_word_unused_s;

`ifdef DEBUG_ROM_FETCH_PREFETCH_EN
   logic                b1_clr_s;
   logic                b1_load_s;
   logic [WORD_W-1:0]   b1_word_s;
   logic                b1_vld_s;
   logic                b1_sel_unused_s;
   logic [INSTR_W-1:0]  b1_half_unused_s;
   logic                pf_pend_r;
   logic                pf_pend_nx_s;
`endif

   assign redirect_lsb_unused_s = redirect_addr_i[1:0];
   assign word_s     = fa_r[ADDR_W-1:3];
   assign word_inc_s = word_s + WORD_ONE;

   assign bus.instr_valid  = (state_r == DRAIN) && b0_vld_s;
   assign bus.instr        = bus.instr_valid ? b0_half_s : {INSTR_W{1'b0}};
   assign bus.instr_addr   = bus.instr_valid ? {word_s, b0_sel_hi_s, 2'b00} : {ADDR_W{1'b0}};
   assign hs_s             = bus.instr_valid && bus.instr_ready;
   assign hi_done_s        = hs_s && b0_sel_hi_s;
   assign busy_o           = (state_r != IDLE);

`ifdef DEBUG_ROM_FETCH_PREFETCH_EN
   assign pf_req_s = (state_r == DRAIN) && b0_vld_s && !b1_vld_s && !pf_pend_r;
`else
   assign pf_req_s = 1'b0;
`endif

   assign bus.req = (state_r == REQ) || pf_req_s;

   // ROM address: current word in REQ, following word for a prefetch, else parked at 0.
   always_comb begin
      bus.addr = {ADDR_W{1'b0}};
      if (state_r == REQ) begin
         bus.addr = {word_s, 3'b000};
      end else if (pf_req_s) begin
         bus.addr = {word_inc_s, 3'b000};
      end else begin
         bus.addr = {ADDR_W{1'b0}};
      end
   end

   // Next-state, fetch address and buffer control; redirect overrides everything.
   always_comb begin
      state_nx_s   = state_r;
      fa_nx_s      = fa_r;
      b0_clr_s     = 1'b0;
      b0_load_s    = 1'b0;
      b0_data_s    = bus.rdata;
      b0_lo_vld_s  = !fa_r[2];
`ifdef DEBUG_ROM_FETCH_PREFETCH_EN
      b1_clr_s     = 1'b0;
      b1_load_s    = 1'b0;
      pf_pend_nx_s = 1'b0;
`endif
      if (redirect_i) begin
         state_nx_s = REQ;
         fa_nx_s    = redirect_addr_i[ADDR_W-1:2];
         b0_clr_s   = 1'b1;
`ifdef DEBUG_ROM_FETCH_PREFETCH_EN
         b1_clr_s   = 1'b1;
`endif
      end else begin
         case (state_r)
            IDLE:    state_nx_s = IDLE;
            REQ:     state_nx_s = WAIT;
            WAIT: begin
               b0_load_s  = 1'b1;
               state_nx_s = DRAIN;
            end
            DRAIN: begin
`ifdef DEBUG_ROM_FETCH_PREFETCH_EN
               pf_pend_nx_s = pf_req_s && !hi_done_s;
`endif
               if (hi_done_s) begin
                  fa_nx_s = {word_inc_s, 1'b0};
`ifdef DEBUG_ROM_FETCH_PREFETCH_EN
                  // Promote the next word without a bubble, from buffer 1 or straight off the ROM.
                  if (b1_vld_s) begin
                     b0_load_s   = 1'b1;
                     b0_data_s   = b1_word_s;
                     b0_lo_vld_s = 1'b1;
                     b1_clr_s    = 1'b1;
                  end else if (pf_pend_r) begin
                     b0_load_s   = 1'b1;
                     b0_lo_vld_s = 1'b1;
                  end else if (pf_req_s) begin
                     state_nx_s  = WAIT;
                  end else begin
                     state_nx_s  = REQ;
                  end
`else
                  state_nx_s = REQ;
`endif
               end else begin
`ifdef DEBUG_ROM_FETCH_PREFETCH_EN
                  if (pf_pend_r) begin
                     b1_load_s = 1'b1;
                  end else begin
                     b1_load_s = 1'b0;
                  end
`else
                  state_nx_s = DRAIN;
`endif
               end
            end
            default: state_nx_s = IDLE;
         endcase
      end
   end

   // State and fetch-address registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r   <= IDLE;
         fa_r      <= {(ADDR_W-2){1'b0}};
`ifdef DEBUG_ROM_FETCH_PREFETCH_EN
         pf_pend_r <= 1'b0;
`endif
      end else begin
         state_r   <= state_nx_s;
         fa_r      <= fa_nx_s;
`ifdef DEBUG_ROM_FETCH_PREFETCH_EN
         pf_pend_r <= pf_pend_nx_s;
`endif
      end
   end

   dbg_fetch_wordbuf u_buf0 (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clr_i         (b0_clr_s),
      .load_i        (b0_load_s),
      .load_data_i   (b0_data_s),
      .load_lo_vld_i (b0_lo_vld_s),
      .consume_i     (hs_s),
      .word_o        (b0_word_unused_s),
      .vld_o         (b0_vld_s),
      .sel_hi_o      (b0_sel_hi_s),
      .half_o        (b0_half_s)
   );

`ifdef DEBUG_ROM_FETCH_PREFETCH_EN
   dbg_fetch_wordbuf u_buf1 (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clr_i         (b1_clr_s),
      .load_i        (b1_load_s),
      .load_data_i   (bus.rdata),
      .load_lo_vld_i (1'b1),
      .consume_i     (1'b0),
      .word_o        (b1_word_s),
      .vld_o         (b1_vld_s),
      .sel_hi_o      (b1_sel_unused_s),
      .half_o        (b1_half_unused_s)
   );
`endif

endmodule
